cache_ctrl: RTL

- Per-cache sequencing FSM for the 4-line direct-mapped MSI cache datapath.
- Accepts one processor request at a time and checks hit status. On a miss it first does a write-back if needed, then a snoop of peer caches, then a bus fill, and finally completes the access.
- Drives the datapath `func`/`snoop_out` controls and requests the shared bus from the system arbiter.
- Sits between the processor and the datapath, one instance per cache.

---
 rtl/cache_pkg.sv | 28 ++
 rtl/cache_ctrl_bus_txn.sv | 40 ++++
 rtl/cache_ctrl.sv | 137 +++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Shared encodings for the MSI cache controller: datapath ops, line status
// and the sequencing FSM state.
package cache_pkg;

  typedef enum logic [1:0] {
    P_READ  = 2'b00,
    P_WRITE = 2'b01,
    B_READ  = 2'b10,
    B_WRITE = 2'b11
  } func_e;

  localparam logic [1:0] EXCL = 2'b11;
  localparam logic [1:0] SHRD = 2'b10;
  localparam logic [1:0] INVL = 2'b00;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOOKUP,
    S_WRITE,
    S_RESP,
    S_WB,
    S_SNOOP,
    S_FILL,
    S_RETRY,
    S_ERR
  } state_e;

endpackage

// File: rtl/cache_ctrl_bus_txn.sv
// Shared-bus handshake used by both write-back and fill: holds the request
// while active and counts granted cycles that have not yet been acked.
module bus_txn #(
  parameter int BUS_TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic active,
  input  logic bus_grant,
  input  logic bus_ack,
  output logic bus_req,
  output logic xfer,
  output logic done,
  output logic timeout
);

  logic [7:0] to_cnt_q, to_cnt_d;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    to_cnt_d = to_cnt_q;
    if (!active) begin
      to_cnt_d = '0;
    end else if (bus_grant && !bus_ack && (to_cnt_q < 8'(BUS_TIMEOUT))) begin
      to_cnt_d = to_cnt_q + 8'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) to_cnt_q <= '0;
    else       to_cnt_q <= to_cnt_d;
  end

  assign bus_req = active;
  assign xfer    = active && bus_grant;
  assign done    = active && bus_grant && bus_ack;
  assign timeout = active && (to_cnt_q == 8'(BUS_TIMEOUT));

endmodule

// File: rtl/cache_ctrl.sv
// Per-cache sequencing FSM: lookup, optional write-back, peer snoop, bus fill
// and re-lookup, with a sticky error on bus timeout or retry exhaustion.
module cache_ctrl
  import cache_pkg::*;
#(
  parameter int SNOOP_WAIT  = 2,
  parameter int BUS_TIMEOUT = 15,
  parameter int MAX_RETRY   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       p_req,
  input  logic       p_rw,
  input  logic       read_hit,
  input  logic       write_hit,
  input  logic [1:0] stat,
  input  logic       snoop_hit_in,
  input  logic       bus_grant,
  input  logic       bus_ack,
  output logic [1:0] func,
  output logic       snoop_out,
  output logic       bus_req,
  output logic       p_ready,
  output logic       err
);

  state_e     state_q, state_d;
  logic       rw_q, rw_d;
  logic [2:0] snoop_cnt_q, snoop_cnt_d;
  logic [1:0] retry_cnt_q, retry_cnt_d;
  logic       err_q, err_d;
  func_e      func_c;
  logic       bus_active, bus_xfer, bus_done, bus_timeout;

  // The datapath self-dirties on write hits, so the dirty-hit flag is not needed here.
  logic unused_write_hit;
  assign unused_write_hit = write_hit;

  assign bus_active = (state_q == S_WB) || (state_q == S_FILL);

  bus_txn #(.BUS_TIMEOUT(BUS_TIMEOUT)) u_bus_txn (
    .clk       (clk),
    .reset     (reset),
    .active    (bus_active),
    .bus_grant (bus_grant),
    .bus_ack   (bus_ack),
    .bus_req   (bus_req),
    .xfer      (bus_xfer),
    .done      (bus_done),
    .timeout   (bus_timeout)
  );

  always_comb begin
    state_d     = state_q;
    rw_d        = rw_q;
    snoop_cnt_d = snoop_cnt_q;
    retry_cnt_d = retry_cnt_q;
    func_c      = P_READ;
    snoop_out   = 1'b0;
    p_ready     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (p_req) begin
          rw_d        = p_rw;
          retry_cnt_d = '0;
          state_d     = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        snoop_cnt_d = '0;
        if (read_hit)          state_d = rw_q ? S_WRITE : S_RESP;
        else if (stat == EXCL) state_d = S_WB;
        else                   state_d = S_SNOOP;
      end
      S_WRITE: begin
        func_c  = P_WRITE;
        state_d = S_RESP;
      end
      S_RESP: begin
        p_ready = 1'b1;
        state_d = S_IDLE;
      end
      S_WB: begin
        snoop_cnt_d = '0;
        if (bus_xfer) func_c = B_WRITE;
        // A transfer still pending at the deadline is abandoned even if acked now.
        if (bus_timeout)   state_d = S_ERR;
        else if (bus_done) state_d = S_SNOOP;
      end
      S_SNOOP: begin
        snoop_out = (snoop_cnt_q == 3'd0);
        if (snoop_hit_in)                          state_d = S_RETRY;
        else if (snoop_cnt_q >= 3'(SNOOP_WAIT))    state_d = S_FILL;
        else                                       snoop_cnt_d = snoop_cnt_q + 3'd1;
      end
      S_FILL: begin
        if (bus_xfer) func_c = B_READ;
        if (bus_timeout)   state_d = S_ERR;
        else if (bus_done) state_d = S_RETRY;
      end
      S_RETRY: begin
        if (retry_cnt_q >= 2'(MAX_RETRY)) begin
          state_d = S_ERR;
        end else begin
          retry_cnt_d = retry_cnt_q + 2'd1;
          state_d     = S_LOOKUP;
        end
      end
      S_ERR: begin
        p_ready = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    err_d = err_q || (state_d == S_ERR);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      rw_q        <= 1'b0;
      snoop_cnt_q <= '0;
      retry_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rw_q        <= rw_d;
      snoop_cnt_q <= snoop_cnt_d;
      retry_cnt_q <= retry_cnt_d;
      err_q       <= err_d;
    end
  end

  assign func = func_c;
  assign err  = err_q;

endmodule
